// File: rtl/orion_types.sv
// Shared Orion core widths and the bypass source encoding used by the operand stage.
package orion_types;

    localparam int XLEN        = 32;
    localparam int RF_IDX_BITS = 5;
    localparam int NUM_REGS    = 1 << RF_IDX_BITS;

    typedef enum logic [1:0] {
        FWD_ZERO = 2'd0,
        FWD_EX   = 2'd1,
        FWD_WB   = 2'd2,
        FWD_RF   = 2'd3
    } fwd_src_e;

endpackage

// File: rtl/operand_stage_bypass.sv
// Combinational operand select for one source: x0, EX bypass, WB bypass, then regfile.
// Zero latency; no flow control of its own.
module operand_bypass
    import orion_types::*;
(
    input  logic [RF_IDX_BITS-1:0] idx,
    input  logic [XLEN-1:0]        rf_v,
    input  logic                   ex_valid,
    input  logic                   ex_is_load,
    input  logic [RF_IDX_BITS-1:0] ex_rd,
    input  logic [XLEN-1:0]        ex_v,
    input  logic                   wb_valid,
    input  logic [RF_IDX_BITS-1:0] wb_rd,
    input  logic [XLEN-1:0]        wb_v,
    output logic [XLEN-1:0]        val
);

    fwd_src_e src;
    logic     idx_nz;

    assign idx_nz = (idx != '0);

    // A load in EX has no result yet, so it never bypasses; the hazard logic stalls instead.
    // WB must win over the regfile because the write only lands at the clock edge.
    always_comb begin
        src = FWD_RF;
        if (!idx_nz) begin
            src = FWD_ZERO;
        end else if (ex_valid && !ex_is_load && (ex_rd == idx)) begin
            src = FWD_EX;
        end else if (wb_valid && (wb_rd == idx)) begin
            src = FWD_WB;
        end
    end

    always_comb begin
        val = rf_v;
        case (src)
            FWD_ZERO: val = '0;
            FWD_EX:   val = ex_v;
            FWD_WB:   val = wb_v;
            default:  val = rf_v;
        endcase
    end

endmodule

// File: rtl/operand_stage.sv
// Operand-read stage: bypass, load-use stall and a 1-cycle valid/ready register to EX; stalls hold the payload.
// Optional ORION_OPSTAGE_PERF_EN adds load-use and backpressure stall counters.
module operand_stage
    import orion_types::*;
#(
    parameter int CTRL_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [RF_IDX_BITS-1:0] in_rs1_s_i,
    input  logic [RF_IDX_BITS-1:0] in_rs2_s_i,
    input  logic                   in_uses_rs1_i,
    input  logic                   in_uses_rs2_i,
    input  logic [RF_IDX_BITS-1:0] in_rd_s_i,
    input  logic [CTRL_W-1:0]      in_ctrl_i,

    output logic [RF_IDX_BITS-1:0] rf_rs1_s_o,
    output logic [RF_IDX_BITS-1:0] rf_rs2_s_o,
    input  logic [XLEN-1:0]        rf_rs1_v_i,
    input  logic [XLEN-1:0]        rf_rs2_v_i,

    input  logic                   ex_fwd_valid_i,
    input  logic                   ex_fwd_is_load_i,
    input  logic [RF_IDX_BITS-1:0] ex_fwd_rd_i,
    input  logic [XLEN-1:0]        ex_fwd_v_i,

    input  logic                   wb_fwd_valid_i,
    input  logic [RF_IDX_BITS-1:0] wb_fwd_rd_i,
    input  logic [XLEN-1:0]        wb_fwd_v_i,

    input  logic                   flush_i,

    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [XLEN-1:0]        out_rs1_v_o,
    output logic [XLEN-1:0]        out_rs2_v_o,
    output logic [RF_IDX_BITS-1:0] out_rd_s_o
`ifdef ORION_OPSTAGE_PERF_EN
    ,
    output logic [CTRL_W-1:0]      out_ctrl_o,
    output logic [31:0]            perf_lu_stall_o,
    output logic [31:0]            perf_bp_stall_o
`else
    ,
    output logic [CTRL_W-1:0]      out_ctrl_o
`endif
);

    logic [XLEN-1:0] rs1_v;
    logic [XLEN-1:0] rs2_v;
    logic            hazard;
    logic            out_free;
    logic            accept;

    assign rf_rs1_s_o = in_rs1_s_i;
    assign rf_rs2_s_o = in_rs2_s_i;

    operand_bypass u_bypass_rs1 (
        .idx        (in_rs1_s_i),
        .rf_v       (rf_rs1_v_i),
        .ex_valid   (ex_fwd_valid_i),
        .ex_is_load (ex_fwd_is_load_i),
        .ex_rd      (ex_fwd_rd_i),
        .ex_v       (ex_fwd_v_i),
        .wb_valid   (wb_fwd_valid_i),
        .wb_rd      (wb_fwd_rd_i),
        .wb_v       (wb_fwd_v_i),
        .val        (rs1_v)
    );

    operand_bypass u_bypass_rs2 (
        .idx        (in_rs2_s_i),
        .rf_v       (rf_rs2_v_i),
        .ex_valid   (ex_fwd_valid_i),
        .ex_is_load (ex_fwd_is_load_i),
        .ex_rd      (ex_fwd_rd_i),
        .ex_v       (ex_fwd_v_i),
        .wb_valid   (wb_fwd_valid_i),
        .wb_rd      (wb_fwd_rd_i),
        .wb_v       (wb_fwd_v_i),
        .val        (rs2_v)
    );

    // Only sources the instruction actually reads can create a load-use stall.
    always_comb begin
        hazard = in_valid_i && ex_fwd_valid_i && ex_fwd_is_load_i && (ex_fwd_rd_i != '0) &&
                 ((in_uses_rs1_i && (in_rs1_s_i == ex_fwd_rd_i)) ||
                  (in_uses_rs2_i && (in_rs2_s_i == ex_fwd_rd_i)));
    end

    assign out_free   = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && !hazard;
    assign in_ready_o = flush_i || (!hazard && out_free);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            out_rs1_v_o <= '0;
            out_rs2_v_o <= '0;
            out_rd_s_o  <= '0;
            out_ctrl_o  <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (out_free) begin
            out_valid_o <= accept;
            if (accept) begin
                out_rs1_v_o <= rs1_v;
                out_rs2_v_o <= rs2_v;
                out_rd_s_o  <= in_rd_s_i;
                out_ctrl_o  <= in_ctrl_i;
            end
        end
    end

`ifdef ORION_OPSTAGE_PERF_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_lu_stall_o <= '0;
            perf_bp_stall_o <= '0;
        end else begin
            if (hazard && !flush_i) begin
                perf_lu_stall_o <= perf_lu_stall_o + 32'd1;
            end
            if (out_valid_o && !out_ready_i) begin
                perf_bp_stall_o <= perf_bp_stall_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_operand_stage.sv
// Directed self-checking bench for operand_stage; one task per scenario.
module tb_operand_stage;
    import orion_types::*;

    localparam int CTRL_W = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   in_valid, in_ready;
    logic [RF_IDX_BITS-1:0] in_rs1, in_rs2, in_rd;
    logic                   in_uses_rs1, in_uses_rs2;
    logic [CTRL_W-1:0]      in_ctrl;
    logic [RF_IDX_BITS-1:0] rf_rs1_s, rf_rs2_s;
    logic [XLEN-1:0]        rf_rs1_v, rf_rs2_v;
    logic                   ex_valid, ex_is_load;
    logic [RF_IDX_BITS-1:0] ex_rd;
    logic [XLEN-1:0]        ex_v;
    logic                   wb_valid;
    logic [RF_IDX_BITS-1:0] wb_rd;
    logic [XLEN-1:0]        wb_v;
    logic                   flush;
    logic                   out_valid, out_ready;
    logic [XLEN-1:0]        out_rs1_v, out_rs2_v;
    logic [RF_IDX_BITS-1:0] out_rd;
    logic [CTRL_W-1:0]      out_ctrl;
`ifdef ORION_OPSTAGE_PERF_EN
    logic [31:0]            perf_lu, perf_bp;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    operand_stage #(.CTRL_W(CTRL_W)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .in_valid_i       (in_valid),
        .in_ready_o       (in_ready),
        .in_rs1_s_i       (in_rs1),
        .in_rs2_s_i       (in_rs2),
        .in_uses_rs1_i    (in_uses_rs1),
        .in_uses_rs2_i    (in_uses_rs2),
        .in_rd_s_i        (in_rd),
        .in_ctrl_i        (in_ctrl),
        .rf_rs1_s_o       (rf_rs1_s),
        .rf_rs2_s_o       (rf_rs2_s),
        .rf_rs1_v_i       (rf_rs1_v),
        .rf_rs2_v_i       (rf_rs2_v),
        .ex_fwd_valid_i   (ex_valid),
        .ex_fwd_is_load_i (ex_is_load),
        .ex_fwd_rd_i      (ex_rd),
        .ex_fwd_v_i       (ex_v),
        .wb_fwd_valid_i   (wb_valid),
        .wb_fwd_rd_i      (wb_rd),
        .wb_fwd_v_i       (wb_v),
        .flush_i          (flush),
        .out_valid_o      (out_valid),
        .out_ready_i      (out_ready),
        .out_rs1_v_o      (out_rs1_v),
        .out_rs2_v_o      (out_rs2_v),
        .out_rd_s_o       (out_rd),
`ifdef ORION_OPSTAGE_PERF_EN
        .out_ctrl_o       (out_ctrl),
        .perf_lu_stall_o  (perf_lu),
        .perf_bp_stall_o  (perf_bp)
`else
        .out_ctrl_o       (out_ctrl)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_uses_rs1 = 0; in_uses_rs2 = 0; in_ctrl = 0;
        rf_rs1_v = 0; rf_rs2_v = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_v = 0;
        wb_valid = 0; wb_rd = 0; wb_v = 0;
        flush = 0; out_ready = 1;
    endtask

    task automatic instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] ctrl);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_uses_rs1 = 1; in_uses_rs2 = 1; in_ctrl = ctrl;
        rf_rs1_v = v1; rf_rs2_v = v2;
    endtask

    task automatic test_reset();
        rst = 1;
        idle();
        out_ready = 0;
        tick(); tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        n_cmp++; if ({out_rs1_v, out_rs2_v, out_rd, out_ctrl} !== '0) begin n_err++;
            $display("FAIL reset_payload got %h %h %h %h exp 0", out_rs1_v, out_rs2_v, out_rd, out_ctrl); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        rst = 0;
        out_ready = 1;
        tick();
    endtask

    task automatic test_back_to_back();
        instr(5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'hC0DE0001);
        n_cmp++; if (rf_rs1_s !== 5'd1 || rf_rs2_s !== 5'd2) begin n_err++;
            $display("FAIL rf_index got %0d/%0d exp 1/2", rf_rs1_s, rf_rs2_s); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_rs1_v !== 32'h11 || out_rs2_v !== 32'h22) begin n_err++;
            $display("FAIL b2b_first got v=%b %h %h exp 1 11 22", out_valid, out_rs1_v, out_rs2_v); end
        n_cmp++; if (out_rd !== 5'd3 || out_ctrl !== 32'hC0DE0001) begin n_err++;
            $display("FAIL b2b_ctrl got %0d %h exp 3 c0de0001", out_rd, out_ctrl); end
        instr(5'd4, 5'd6, 5'd8, 32'h33, 32'h44, 32'hC0DE0002);
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_rs1_v !== 32'h33 || out_rs2_v !== 32'h44 || out_ctrl !== 32'hC0DE0002) begin n_err++;
            $display("FAIL b2b_second got v=%b %h %h %h exp 1 33 44 c0de0002", out_valid, out_rs1_v, out_rs2_v, out_ctrl); end
        idle();
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_bypass();
        instr(5'd5, 5'd9, 5'd1, 32'h5555, 32'h9999, 32'h0);
        ex_valid = 1; ex_rd = 5'd5; ex_v = 32'hAAAA;
        wb_valid = 1; wb_rd = 5'd5; wb_v = 32'hBBBB;
        tick();
        n_cmp++; if (out_rs1_v !== 32'hAAAA || out_rs2_v !== 32'h9999) begin n_err++;
            $display("FAIL bypass_ex_prio got %h %h exp aaaa 9999", out_rs1_v, out_rs2_v); end
        ex_valid = 0;
        tick();
        n_cmp++; if (out_rs1_v !== 32'hBBBB) begin n_err++; $display("FAIL bypass_wb got %h exp bbbb", out_rs1_v); end
        in_rs1 = 5'd0; rf_rs1_v = 32'h99;
        ex_valid = 1; ex_rd = 5'd0; ex_v = 32'hDEAD;
        wb_rd = 5'd0;
        tick();
        n_cmp++; if (out_rs1_v !== 32'h0) begin n_err++; $display("FAIL bypass_x0 got %h exp 0", out_rs1_v); end
        idle();
        tick();
    endtask

    task automatic test_load_use();
        instr(5'd1, 5'd7, 5'd2, 32'h10, 32'h77, 32'h0);
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd7; ex_v = 32'hFFFF;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL lu_in_ready got %b exp 0", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lu_bubble got %b exp 0", out_valid); end
        ex_is_load = 0; ex_v = 32'h1234;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lu_release_ready got %b exp 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_rs2_v !== 32'h1234) begin n_err++;
            $display("FAIL lu_fwd got v=%b %h exp 1 1234", out_valid, out_rs2_v); end
        ex_is_load = 1; in_uses_rs2 = 0;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL lu_unused_ready got %b exp 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_rs2_v !== 32'h77) begin n_err++;
            $display("FAIL lu_unused got v=%b %h exp 1 77", out_valid, out_rs2_v); end
        idle();
        tick();
    endtask

    task automatic test_backpressure();
        instr(5'd1, 5'd2, 5'd3, 32'h5A, 32'h5B, 32'hA);
        tick();
        out_ready = 0;
        instr(5'd1, 5'd2, 5'd4, 32'h6A, 32'h6B, 32'hB);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
            tick();
            n_cmp++; if (out_valid !== 1'b1 || out_rs1_v !== 32'h5A || out_ctrl !== 32'hA) begin n_err++;
                $display("FAIL bp_hold[%0d] got v=%b %h %h exp 1 5a a", i, out_valid, out_rs1_v, out_ctrl); end
        end
        out_ready = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready got %b exp 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b1 || out_rs1_v !== 32'h6A || out_rd !== 5'd4) begin n_err++;
            $display("FAIL bp_next got v=%b %h %0d exp 1 6a 4", out_valid, out_rs1_v, out_rd); end
        idle();
        tick();
    endtask

    task automatic test_flush_and_reset();
        instr(5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);
        tick();
        out_ready = 0;
        instr(5'd4, 5'd5, 5'd6, 32'h4, 32'h5, 32'h6);
        flush = 1;
        #1;
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready got %b exp 1", in_ready); end
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_kill got %b exp 0", out_valid); end
        flush = 0; in_valid = 0; out_ready = 1;
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_discard got %b exp 0", out_valid); end
        instr(5'd1, 5'd2, 5'd3, 32'hCAFE, 32'h2, 32'h3);
        tick();
        idle();
        #3;
        rst = 1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_rs1_v !== 32'h0) begin n_err++;
            $display("FAIL async_reset got v=%b %h exp 0 0", out_valid, out_rs1_v); end
        tick();
        rst = 0;
        tick();
    endtask

`ifdef ORION_OPSTAGE_PERF_EN
    task automatic test_perf();
        rst = 1; idle(); tick(); rst = 0;
        n_cmp++; if (perf_lu !== 32'd0 || perf_bp !== 32'd0) begin n_err++;
            $display("FAIL perf_reset got %0d %0d exp 0 0", perf_lu, perf_bp); end
        instr(5'd1, 5'd7, 5'd2, 32'h1, 32'h2, 32'h0);
        ex_valid = 1; ex_is_load = 1; ex_rd = 5'd7;
        tick(); tick();
        ex_valid = 0;
        tick();
        in_valid = 0; out_ready = 0;
        tick(); tick(); tick();
        out_ready = 1;
        tick();
        n_cmp++; if (perf_lu !== 32'd2) begin n_err++; $display("FAIL perf_lu got %0d exp 2", perf_lu); end
        n_cmp++; if (perf_bp !== 32'd3) begin n_err++; $display("FAIL perf_bp got %0d exp 3", perf_bp); end
        idle();
    endtask
`endif

    initial begin
        test_reset();
        test_back_to_back();
        test_bypass();
        test_load_use();
        test_backpressure();
        test_flush_and_reset();
`ifdef ORION_OPSTAGE_PERF_EN
        test_perf();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
